mem_arbiter: RTL and testbench

//  Two-client arbiter sharing one single-port BRAM memory (put/get valid-ready protocol) between

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_tag_fifo.sv | 55 +++++
 rtl/mem_arbiter.sv | 62 ++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared memory-operation types for the two-client BRAM arbiter.
// An op is {byte_en, addr, data}; byte_en == 0 means read, otherwise a masked write.
package mem_pkg;
  localparam int REQ_ADDR_WIDTH = 32;
  localparam int REQ_DATA_WIDTH = 32;
  localparam int REQ_BE_WIDTH   = 4;
  localparam int MEM_OP_SIZE    = REQ_BE_WIDTH + REQ_ADDR_WIDTH + REQ_DATA_WIDTH;

  typedef struct packed {
    logic [REQ_BE_WIDTH-1:0]   byte_en;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] data;
  } mem_op_t;

  typedef logic client_id_t;

  localparam client_id_t CLIENT_IF = 1'b0;  // instruction fetch
  localparam client_id_t CLIENT_LS = 1'b1;  // load/store
endpackage

// File: rtl/mem_arbiter_if.sv
// Put/get valid-ready port bundle. The master issues requests and takes responses;
// the slave accepts requests and produces responses.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic    put_valid;
  mem_op_t put_request;
  logic    put_ready;
  logic    get_valid;
  logic    get_ready;
  mem_op_t get_response;

  modport master (
    output put_valid, put_request, get_valid,
    input  put_ready, get_ready, get_response
  );

  modport slave (
    input  put_valid, put_request, get_valid,
    output put_ready, get_ready, get_response
  );
endinterface

// File: rtl/mem_tag_fifo.sv
// Owner-tag FIFO: records which client issued each outstanding memory request.
// Head is read combinationally so the response can be steered in the same cycle.
module mem_tag_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  client_id_t push_id_i,
  input  logic       pop_i,
  output client_id_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  client_id_t       tags_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = tags_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= CLIENT_IF;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) tags_q[wr_ptr_q] <= push_id_i;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction-fetch and load/store
// clients; responses are steered back in issue order using the owner-tag FIFO.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TAG_DEPTH = 2
) (
  input  logic CLK,
  input  logic RST_N,
  mem_arbiter_if.slave  c0_if,
  mem_arbiter_if.slave  c1_if,
  mem_arbiter_if.master mem_if
);
  client_id_t prio_q, prio_d;
  client_id_t head;
  logic       tag_full, tag_empty;
  logic       can_issue, rdy0, rdy1, grant0, grant1;
  logic       head_get_valid, pop;

  mem_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .push_i   (grant0 || grant1),
    .push_id_i(grant1 ? CLIENT_LS : CLIENT_IF),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (tag_full),
    .empty_o  (tag_empty)
  );

  // Readies look only at the other client's valid, so no client sees its own valid looped back.
  always_comb begin
    can_issue = RST_N && mem_if.put_ready && !tag_full;
    rdy0      = can_issue && (prio_q == CLIENT_IF || !c1_if.put_valid);
    rdy1      = can_issue && (prio_q == CLIENT_LS || !c0_if.put_valid);
    grant0    = c0_if.put_valid && rdy0;
    grant1    = c1_if.put_valid && rdy1;
    prio_d    = prio_q;
    if (grant0)      prio_d = CLIENT_LS;
    else if (grant1) prio_d = CLIENT_IF;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) prio_q <= CLIENT_IF;
    else        prio_q <= prio_d;
  end

  assign c0_if.put_ready     = rdy0;
  assign c1_if.put_ready     = rdy1;
  assign mem_if.put_valid    = grant0 || grant1;
  assign mem_if.put_request  = grant1 ? c1_if.put_request : c0_if.put_request;

  // Only the head owner may consume; a stalled head blocks later responses on purpose.
  assign head_get_valid      = (head == CLIENT_LS) ? c1_if.get_valid : c0_if.get_valid;
  assign mem_if.get_valid    = RST_N && !tag_empty && head_get_valid;
  assign pop                 = mem_if.get_valid && mem_if.get_ready;

  assign c0_if.get_ready     = RST_N && !tag_empty && (head == CLIENT_IF) && mem_if.get_ready;
  assign c1_if.get_ready     = RST_N && !tag_empty && (head == CLIENT_LS) && mem_if.get_ready;
  assign c0_if.get_response  = mem_if.get_response;
  assign c1_if.get_response  = mem_if.get_response;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed traffic against a queue-based owner/priority model
// and a one-cycle-latency memory model, checked every cycle plus literal spot checks.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int TAG_DEPTH = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if c0_if();
  mem_arbiter_if c1_if();
  mem_arbiter_if mem_if();

  mem_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .c0_if (c0_if),
    .c1_if (c1_if),
    .mem_if(mem_if)
  );

  logic    pv [2];
  mem_op_t preq [2];
  logic    gv [2];
  logic    mput_rdy, resp_en, mgr;
  mem_op_t mrsp;

  assign c0_if.put_valid    = pv[0];
  assign c0_if.put_request  = preq[0];
  assign c0_if.get_valid    = gv[0];
  assign c1_if.put_valid    = pv[1];
  assign c1_if.put_request  = preq[1];
  assign c1_if.get_valid    = gv[1];
  assign mem_if.put_ready   = mput_rdy;
  assign mem_if.get_ready   = mgr;
  assign mem_if.get_response = mrsp;

  // Model state: owner list in issue order, priority, memory contents and pending responses.
  int          tagq [$];
  int          prio;
  mem_op_t     mq [$];
  logic [31:0] marr [logic [31:0]];
  int          grant_log [$];
  int          deliv_log [$];
  mem_op_t     rsp_log0 [$];
  mem_op_t     rsp_log1 [$];
  int          gcnt [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic mem_op_t mk_op(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    mem_op_t o;
    o.byte_en = be;
    o.addr    = a;
    o.data    = d;
    return o;
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh_mem();
    mgr  = resp_en && (mq.size() > 0);
    mrsp = (mq.size() > 0) ? mq[0] : '0;
  endtask

  task automatic mem_accept(input mem_op_t op);
    mem_op_t     r;
    logic [31:0] word;
    r = op;
    word = marr.exists(op.addr) ? marr[op.addr] : 32'h0;
    if (op.byte_en == 4'b0000) begin
      r.data = word;
    end else begin
      for (int b = 0; b < 4; b++)
        if (op.byte_en[b]) word[8*b +: 8] = op.data[8*b +: 8];
      marr[op.addr] = word;
    end
    mq.push_back(r);
  endtask

  // Scoreboard: just before each rising edge, derive every output from the model and compare.
  initial begin : scoreboard
    logic    e_can, e_r0, e_r1, e_g0, e_g1, e_mpv, e_gr0, e_gr1, e_mgv, nonempty;
    logic    rst_c, act_mpv, act_pop, do_pop;
    mem_op_t e_req, act_req;
    int      head;
    forever begin
      @(negedge CLK);
      #4;
      e_can    = RST_N && mput_rdy && (tagq.size() < TAG_DEPTH);
      e_r0     = e_can && (prio == 0 || !pv[1]);
      e_r1     = e_can && (prio == 1 || !pv[0]);
      e_g0     = pv[0] && e_r0;
      e_g1     = pv[1] && e_r1;
      e_mpv    = e_g0 || e_g1;
      e_req    = e_g1 ? preq[1] : preq[0];
      nonempty = RST_N && (tagq.size() > 0);
      head     = (tagq.size() > 0) ? tagq[0] : 0;
      e_gr0    = nonempty && head == 0 && mgr;
      e_gr1    = nonempty && head == 1 && mgr;
      e_mgv    = nonempty && gv[head];

      chk("handshake {r0,r1,mpv,gr0,gr1,mgv}",
          68'({c0_if.put_ready, c1_if.put_ready, mem_if.put_valid,
               c0_if.get_ready, c1_if.get_ready, mem_if.get_valid}),
          68'({e_r0, e_r1, e_mpv, e_gr0, e_gr1, e_mgv}));
      if (e_mpv) chk("mem_put_request", 68'(mem_if.put_request), 68'(e_req));
      if (e_gr0) chk("c0_get_response", 68'(c0_if.get_response), 68'(mrsp));
      if (e_gr1) chk("c1_get_response", 68'(c1_if.get_response), 68'(mrsp));

      rst_c   = RST_N;
      do_pop  = e_mgv && mgr;
      act_mpv = mem_if.put_valid && mput_rdy;
      act_req = mem_if.put_request;
      act_pop = mem_if.get_valid && mgr;
      if (do_pop) begin
        deliv_log.push_back(head);
        if (head == 0) rsp_log0.push_back(mrsp);
        else           rsp_log1.push_back(mrsp);
      end

      @(posedge CLK);
      #1;
      if (!rst_c) begin
        tagq.delete();
        mq.delete();
        prio = 0;
      end else begin
        if (do_pop) void'(tagq.pop_front());
        if (e_g0) begin
          tagq.push_back(0); prio = 1; grant_log.push_back(0); gcnt[0]++;
        end else if (e_g1) begin
          tagq.push_back(1); prio = 0; grant_log.push_back(1); gcnt[1]++;
        end
        if (act_pop && mq.size() > 0) void'(mq.pop_front());
        if (act_mpv) mem_accept(act_req);
      end
      refresh_mem();
    end
  end

  task automatic put(input int id, input mem_op_t op);
    int   start;
    logic done;
    start = gcnt[id];
    done  = 1'b0;
    pv[id]   = 1'b1;
    preq[id] = op;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge CLK);
      #2;
      if (gcnt[id] > start) done = 1'b1;
    end
    chk("put grant within bound", 68'(done), 68'(1));
    @(negedge CLK);
    pv[id] = 1'b0;
  endtask

  task automatic wait_deliv(input int n);
    for (int k = 0; k < 200 && deliv_log.size() < n; k++) @(negedge CLK);
    chk("responses delivered within bound", 68'(deliv_log.size() >= n), 68'(1));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && (tagq.size() > 0 || mq.size() > 0); k++) @(negedge CLK);
    chk("drain within bound", 68'(tagq.size() == 0 && mq.size() == 0), 68'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int      base, d0, n1;
    logic    done;
    mem_op_t t;
    pv[0] = 1'b0; pv[1] = 1'b0; gv[0] = 1'b0; gv[1] = 1'b0;
    preq[0] = '0; preq[1] = '0;
    mput_rdy = 1'b1; resp_en = 1'b1;
    prio = 0; gcnt[0] = 0; gcnt[1] = 0;
    marr[32'h100] = 32'hDEADBEEF;
    refresh_mem();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Reset mid-traffic with one tag queued
    put(0, mk_op(4'h0, 32'h100, 32'h0));
    repeat (2) @(negedge CLK);
    pv[0] = 1'b1; pv[1] = 1'b1; gv[0] = 1'b1; gv[1] = 1'b1;
    preq[0] = mk_op(4'h0, 32'h300, 32'h0);
    preq[1] = mk_op(4'h0, 32'h304, 32'h0);
    #1 chk("tag queued before reset", 68'(mem_if.get_valid), 68'(1));
    RST_N = 1'b0;
    #1 chk("outputs gated in reset",
           68'({c0_if.put_ready, c1_if.put_ready, mem_if.put_valid,
                c0_if.get_ready, c1_if.get_ready, mem_if.get_valid}), 68'(0));
    repeat (2) @(negedge CLK);
    pv[0] = 1'b0; pv[1] = 1'b0;
    RST_N = 1'b1;
    #1 chk("fifo empty after reset", 68'(mem_if.get_valid), 68'(0));

    // Contention from reset: strict alternation starting with client 0
    pv[0] = 1'b1; pv[1] = 1'b1;
    #1 chk("prio 0 after reset {r0,r1}", 68'({c0_if.put_ready, c1_if.put_ready}), 68'(2'b10));
    base = grant_log.size();
    d0   = deliv_log.size();
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge CLK);
      #2;
      if (grant_log.size() >= base + 8) done = 1'b1;
    end
    chk("8 contention grants within bound", 68'(done), 68'(1));
    @(negedge CLK);
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (base + i < grant_log.size()) chk("grant order", 68'(grant_log[base+i]), 68'(i % 2));
    wait_deliv(d0 + 8);
    wait_idle();

    // Single client read
    d0 = deliv_log.size();
    n1 = rsp_log1.size();
    put(0, mk_op(4'h0, 32'h100, 32'h0));
    wait_deliv(d0 + 1);
    t = rsp_log0[rsp_log0.size()-1];
    chk("c0 read 0x100 data", 68'(t.data), 68'(32'hDEADBEEF));
    chk("no c1 response on c0 read", 68'(rsp_log1.size()), 68'(n1));

    // Write by c1 then read by c0: in-order delivery
    d0 = deliv_log.size();
    put(1, mk_op(4'hF, 32'h200, 32'h12345678));
    put(0, mk_op(4'h0, 32'h200, 32'h0));
    wait_deliv(d0 + 2);
    chk("first response owner", 68'(deliv_log[d0]), 68'(1));
    chk("second response owner", 68'(deliv_log[d0+1]), 68'(0));
    t = rsp_log1[rsp_log1.size()-1];
    chk("c1 write ack", 68'(t), 68'(mk_op(4'hF, 32'h200, 32'h12345678)));
    t = rsp_log0[rsp_log0.size()-1];
    chk("c0 read-after-write data", 68'(t.data), 68'(32'h12345678));

    // Head-of-line stall on client 0
    gv[0] = 1'b0; gv[1] = 1'b1;
    d0 = deliv_log.size();
    n1 = rsp_log1.size();
    put(0, mk_op(4'h0, 32'h200, 32'h0));
    put(1, mk_op(4'h0, 32'h100, 32'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1 chk("stalled head {mgv,c1_gr}", 68'({mem_if.get_valid, c1_if.get_ready}), 68'(0));
    end
    chk("no c1 response while stalled", 68'(rsp_log1.size()), 68'(n1));
    gv[0] = 1'b1;
    wait_deliv(d0 + 2);
    chk("stall release owner 0 first", 68'(deliv_log[d0]), 68'(0));
    chk("stall release owner 1 second", 68'(deliv_log[d0+1]), 68'(1));
    t = rsp_log1[rsp_log1.size()-1];
    chk("c1 read 0x100 data", 68'(t.data), 68'(32'hDEADBEEF));
    wait_idle();

    // Full tag FIFO
    resp_en = 1'b0;
    refresh_mem();
    put(0, mk_op(4'h0, 32'h100, 32'h0));
    put(1, mk_op(4'h0, 32'h200, 32'h0));
    pv[0] = 1'b1; pv[1] = 1'b1;
    preq[0] = mk_op(4'h0, 32'h300, 32'h0);
    preq[1] = mk_op(4'h0, 32'h304, 32'h0);
    #1 chk("full blocks puts", 68'({c0_if.put_ready, c1_if.put_ready}), 68'(0));
    repeat (2) @(negedge CLK);
    #1 chk("full still blocks puts", 68'({c0_if.put_ready, c1_if.put_ready}), 68'(0));
    resp_en = 1'b1;
    refresh_mem();
    #1 chk("full: pop without push {pop,r0,r1}",
           68'({mem_if.get_valid && mgr, c0_if.put_ready, c1_if.put_ready}), 68'(3'b100));
    @(negedge CLK);
    #1 chk("push+pop {pop,r0,r1}",
           68'({mem_if.get_valid && mgr, c0_if.put_ready, c1_if.put_ready}), 68'(3'b110));
    @(negedge CLK);
    #1 chk("count held {pop,r0,r1}",
           68'({mem_if.get_valid && mgr, c0_if.put_ready, c1_if.put_ready}), 68'(3'b101));
    repeat (3) @(negedge CLK);
    pv[0] = 1'b0; pv[1] = 1'b0;
    wait_idle();

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
